addsub_exec_ctrl: RTL and testbench

- Issue/writeback controller wrapped around the combinational modular adder-subtractor (AddSubMod).
- Accepts add/sub instructions, fetches operands from a synchronous-read register file and drives the AddSubMod inputs.
- Captures the reduced result and writes it back to the register file.
- Three-stage pipeline (fetch, execute, writeback) with full RAW forwarding, so back-to-back dependent instructions run at one per cycle with no stalls.

---
 rtl/addsub_exec_ctrl_if.sv | 50 +++++
 rtl/addsub_exec_ctrl.sv | 166 ++++++++++++++++
 tb/tb_addsub_exec_ctrl.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/addsub_exec_ctrl_if.sv
// Bundle of the instruction, register-file, AddSubMod and completion signals
// used by the add/sub issue/writeback controller.
interface addsub_exec_ctrl_if #(
  parameter int WORD_SIZE = 8,
  parameter int ADDR_W    = 5,
  parameter int TAG_W     = 4
);
  // Instruction port
  logic                 in_valid;
  logic                 in_ready;
  logic                 in_issub;
  logic [ADDR_W-1:0]    in_srca;
  logic [ADDR_W-1:0]    in_srcb;
  logic [ADDR_W-1:0]    in_dst;
  logic [TAG_W-1:0]     in_tag;
  logic                 hold;
  // Register file (synchronous read, read-first)
  logic [ADDR_W-1:0]    rf_raddr_a;
  logic [ADDR_W-1:0]    rf_raddr_b;
  logic [WORD_SIZE-1:0] rf_rdata_a;
  logic [WORD_SIZE-1:0] rf_rdata_b;
  logic                 rf_we;
  logic [ADDR_W-1:0]    rf_waddr;
  logic [WORD_SIZE-1:0] rf_wdata;
  // Combinational modular adder-subtractor
  logic [WORD_SIZE-1:0] as_inA;
  logic [WORD_SIZE-1:0] as_inB;
  logic                 as_issub;
  logic [WORD_SIZE-1:0] as_out;
  // Completion / status
  logic                 done_valid;
  logic [TAG_W-1:0]     done_tag;
  logic                 busy;

  // Controller side
  modport slave (
    input  in_valid, in_issub, in_srca, in_srcb, in_dst, in_tag, hold,
    input  rf_rdata_a, rf_rdata_b, as_out,
    output in_ready, rf_raddr_a, rf_raddr_b, rf_we, rf_waddr, rf_wdata,
    output as_inA, as_inB, as_issub, done_valid, done_tag, busy
  );

  // Host / environment side (issuer, RAM, AddSubMod)
  modport master (
    output in_valid, in_issub, in_srca, in_srcb, in_dst, in_tag, hold,
    output rf_rdata_a, rf_rdata_b, as_out,
    input  in_ready, rf_raddr_a, rf_raddr_b, rf_we, rf_waddr, rf_wdata,
    input  as_inA, as_inB, as_issub, done_valid, done_tag, busy
  );
endinterface

// File: rtl/addsub_exec_ctrl.sv
// Issue/writeback controller around a combinational modular adder-subtractor.
// Three stages: fetch (p0, RAM address), execute (p1, operand select and
// AddSubMod drive), writeback (p2, register-file write and completion).
// Full RAW forwarding from the writeback stage and from a last-write register
// lets dependent instructions issue every cycle without stalls.
module addsub_exec_ctrl #(
  parameter int WORD_SIZE = 8,
  parameter int ADDR_W    = 5,
  parameter int TAG_W     = 4
) (
  input  logic              clk,
  input  logic              rst,
  addsub_exec_ctrl_if.slave bus
);

  // Operand select: the younger in-flight result wins over the last write,
  // which wins over the (possibly stale) RAM read data.
  function automatic logic [WORD_SIZE-1:0] fwd_sel(
    input logic [ADDR_W-1:0]    src,
    input logic [WORD_SIZE-1:0] ram_data,
    input logic                 s2_vld,
    input logic [ADDR_W-1:0]    s2_dst,
    input logic [WORD_SIZE-1:0] s2_data,
    input logic                 lw_vld,
    input logic [ADDR_W-1:0]    lw_addr,
    input logic [WORD_SIZE-1:0] lw_data
  );
    logic [WORD_SIZE-1:0] res;
    res = ram_data;
    if (s2_vld && (s2_dst == src)) begin
      res = s2_data;
    end else if (lw_vld && (lw_addr == src)) begin
      res = lw_data;
    end
    return res;
  endfunction

  // ---------------------------------------------------------------------
  // p0: fetch -- RAM addresses straight from the instruction port
  // ---------------------------------------------------------------------
  logic accept_p0;

  assign bus.in_ready   = ~bus.hold;
  assign accept_p0      = bus.in_valid & ~bus.hold;
  assign bus.rf_raddr_a = bus.in_srca;
  assign bus.rf_raddr_b = bus.in_srcb;

  logic                 vld_p1_q,   vld_p1_d;
  logic                 issub_p1_q;
  logic [ADDR_W-1:0]    srca_p1_q;
  logic [ADDR_W-1:0]    srcb_p1_q;
  logic [ADDR_W-1:0]    dst_p1_q;
  logic [TAG_W-1:0]     tag_p1_q;

  assign vld_p1_d = accept_p0;

  // Execute-stage valid bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1_q <= 1'b0;
    end else begin
      vld_p1_q <= vld_p1_d;
    end
  end

  // Execute-stage instruction fields, loaded only on accept
  always_ff @(posedge clk) begin
    if (accept_p0) begin
      issub_p1_q <= bus.in_issub;
      srca_p1_q  <= bus.in_srca;
      srcb_p1_q  <= bus.in_srcb;
      dst_p1_q   <= bus.in_dst;
      tag_p1_q   <= bus.in_tag;
    end
  end

  // ---------------------------------------------------------------------
  // p1: execute -- forwarding and AddSubMod drive
  // ---------------------------------------------------------------------
  logic                 vld_p2_q;
  logic [ADDR_W-1:0]    dst_p2_q;
  logic [TAG_W-1:0]     tag_p2_q;
  logic [WORD_SIZE-1:0] data_p2_q;

  logic                 lw_vld_q;
  logic [ADDR_W-1:0]    lw_addr_q;
  logic [WORD_SIZE-1:0] lw_data_q;

  logic [WORD_SIZE-1:0] opa_p1, opb_p1;
  logic [WORD_SIZE-1:0] opa_hold_q, opb_hold_q;
  logic                 issub_hold_q;

  // Forwarded operand selection for both sources
  always_comb begin
    opa_p1 = fwd_sel(srca_p1_q, bus.rf_rdata_a,
                     vld_p2_q, dst_p2_q, data_p2_q,
                     lw_vld_q, lw_addr_q, lw_data_q);
    opb_p1 = fwd_sel(srcb_p1_q, bus.rf_rdata_b,
                     vld_p2_q, dst_p2_q, data_p2_q,
                     lw_vld_q, lw_addr_q, lw_data_q);
  end

  // The adder inputs keep their last driven value while execute is empty
  assign bus.as_inA   = vld_p1_q ? opa_p1     : opa_hold_q;
  assign bus.as_inB   = vld_p1_q ? opb_p1     : opb_hold_q;
  assign bus.as_issub = vld_p1_q ? issub_p1_q : issub_hold_q;

  // Remember the last operands presented to the adder
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opa_hold_q   <= '0;
      opb_hold_q   <= '0;
      issub_hold_q <= 1'b0;
    end else if (vld_p1_q) begin
      opa_hold_q   <= opa_p1;
      opb_hold_q   <= opb_p1;
      issub_hold_q <= issub_p1_q;
    end
  end

  // Capture the reduced result into writeback
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p2_q  <= 1'b0;
      dst_p2_q  <= '0;
      tag_p2_q  <= '0;
      data_p2_q <= '0;
    end else begin
      vld_p2_q <= vld_p1_q;
      if (vld_p1_q) begin
        dst_p2_q  <= dst_p1_q;
        tag_p2_q  <= tag_p1_q;
        data_p2_q <= bus.as_out;
      end
    end
  end

  // ---------------------------------------------------------------------
  // p2: writeback -- register-file write, completion pulse
  // ---------------------------------------------------------------------
  assign bus.rf_we      = vld_p2_q;
  assign bus.rf_waddr   = dst_p2_q;
  assign bus.rf_wdata   = data_p2_q;
  assign bus.done_valid = vld_p2_q;
  assign bus.done_tag   = tag_p2_q;
  assign bus.busy       = vld_p1_q | vld_p2_q;

  // Last-write valid: covers a read issued on the same edge as the write,
  // which a read-first RAM would answer with the old contents
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lw_vld_q <= 1'b0;
    end else begin
      lw_vld_q <= vld_p2_q;
    end
  end

  // Last-write address and data
  always_ff @(posedge clk) begin
    if (vld_p2_q) begin
      lw_addr_q <= dst_p2_q;
      lw_data_q <= data_p2_q;
    end
  end

endmodule

// File: tb/tb_addsub_exec_ctrl.sv
// Directed bench for addsub_exec_ctrl with a read-first RAM model and a
// modular add/sub model (p = 251, 8-bit words).
module tb_addsub_exec_ctrl;
  localparam int W = 8;
  localparam int A = 5;
  localparam int T = 4;
  localparam int P = 251;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  addsub_exec_ctrl_if #(.WORD_SIZE(W), .ADDR_W(A), .TAG_W(T)) bus ();

  addsub_exec_ctrl #(.WORD_SIZE(W), .ADDR_W(A), .TAG_W(T)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file: synchronous, read-first, with a bench preload port
  logic [W-1:0] mem [0:31];
  logic         pre_we;
  logic [A-1:0] pre_addr;
  logic [W-1:0] pre_data;

  always @(posedge clk) begin
    bus.rf_rdata_a <= mem[bus.rf_raddr_a];
    bus.rf_rdata_b <= mem[bus.rf_raddr_b];
    if (bus.rf_we) mem[bus.rf_waddr] <= bus.rf_wdata;
    else if (pre_we) mem[pre_addr] <= pre_data;
  end

  // Modular adder-subtractor
  logic [W:0] t9;
  always_comb begin
    if (bus.as_issub) begin
      if (bus.as_inA >= bus.as_inB) t9 = {1'b0, bus.as_inA} - {1'b0, bus.as_inB};
      else t9 = {1'b0, bus.as_inA} + 9'(P) - {1'b0, bus.as_inB};
    end else begin
      t9 = {1'b0, bus.as_inA} + {1'b0, bus.as_inB};
      if (t9 >= 9'(P)) t9 = t9 - 9'(P);
    end
    bus.as_out = t9[W-1:0];
  end

  task automatic set_instr(input logic v, input logic sub, input int sa, input int sb,
                           input int d, input int tg);
    bus.in_valid = v;
    bus.in_issub = sub;
    bus.in_srca  = A'(sa);
    bus.in_srcb  = A'(sb);
    bus.in_dst   = A'(d);
    bus.in_tag   = T'(tg);
  endtask

  task automatic preload(input int addr, input int data);
    pre_we   = 1'b1;
    pre_addr = A'(addr);
    pre_data = W'(data);
    @(negedge clk);
    pre_we   = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    for (int i = 0; i < 32; i++) preload(i, (i == 1) ? 5 : (i == 2) ? 3 : 0);
    n_tests++; if (bus.rf_we !== 1'b0) begin n_fail++; $display("FAIL rst_we: got %b want 0", bus.rf_we); end
    n_tests++; if (bus.done_valid !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b want 0", bus.done_valid); end
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
    n_tests++; if (bus.rf_wdata !== 8'd0 || bus.rf_waddr !== 5'd0 || bus.done_tag !== 4'd0)
      begin n_fail++; $display("FAIL rst_wb: got waddr %0d wdata %0d tag %0d want 0", bus.rf_waddr, bus.rf_wdata, bus.done_tag); end
    n_tests++; if (bus.as_inA !== 8'd0 || bus.as_inB !== 8'd0 || bus.as_issub !== 1'b0)
      begin n_fail++; $display("FAIL rst_as: got %0d %0d %b want 0", bus.as_inA, bus.as_inB, bus.as_issub); end
    rst = 1'b0;
    #1;
    n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b want 1", bus.in_ready); end
    @(negedge clk);
  endtask

  task automatic test_add;
    set_instr(1, 0, 1, 2, 4, 1);
    @(negedge clk);
    set_instr(0, 0, 0, 0, 0, 0);
    n_tests++; if (bus.busy !== 1'b1 || bus.as_inA !== 8'd5 || bus.as_inB !== 8'd3)
      begin n_fail++; $display("FAIL add_exec: got busy %b A %0d B %0d want 1 5 3", bus.busy, bus.as_inA, bus.as_inB); end
    n_tests++; if (bus.rf_we !== 1'b0) begin n_fail++; $display("FAIL add_early_we: got %b want 0", bus.rf_we); end
    @(negedge clk);
    n_tests++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd4 || bus.rf_wdata !== 8'd8)
      begin n_fail++; $display("FAIL add_wb: got we %b addr %0d data %0d want 1 4 8", bus.rf_we, bus.rf_waddr, bus.rf_wdata); end
    n_tests++; if (bus.done_valid !== 1'b1 || bus.done_tag !== 4'd1)
      begin n_fail++; $display("FAIL add_done: got %b tag %0d want 1 1", bus.done_valid, bus.done_tag); end
    @(negedge clk);
    n_tests++; if (bus.rf_we !== 1'b0 || bus.done_valid !== 1'b0 || bus.busy !== 1'b0)
      begin n_fail++; $display("FAIL add_drain: got we %b done %b busy %b want 0", bus.rf_we, bus.done_valid, bus.busy); end
  endtask

  task automatic test_sub_wrap;
    set_instr(1, 1, 2, 1, 5, 2);
    @(negedge clk);
    set_instr(0, 0, 0, 0, 0, 0);
    n_tests++; if (bus.as_issub !== 1'b1) begin n_fail++; $display("FAIL sub_issub: got %b want 1", bus.as_issub); end
    @(negedge clk);
    n_tests++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd5 || bus.rf_wdata !== 8'd249 || bus.done_tag !== 4'd2)
      begin n_fail++; $display("FAIL sub_wrap: got we %b addr %0d data %0d tag %0d want 1 5 249 2", bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.done_tag); end
    @(negedge clk);
    n_tests++; if (bus.as_inA !== 8'd3 || bus.as_inB !== 8'd5 || bus.as_issub !== 1'b1)
      begin n_fail++; $display("FAIL sub_hold_as: got %0d %0d %b want 3 5 1", bus.as_inA, bus.as_inB, bus.as_issub); end
  endtask

  task automatic test_back_to_back;
    preload(4, 100);
    set_instr(1, 0, 1, 2, 4, 3);
    @(negedge clk);
    set_instr(1, 0, 4, 4, 6, 4);
    @(negedge clk);
    n_tests++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd4 || bus.rf_wdata !== 8'd8)
      begin n_fail++; $display("FAIL b2b_1: got we %b addr %0d data %0d want 1 4 8", bus.rf_we, bus.rf_waddr, bus.rf_wdata); end
    n_tests++; if (bus.as_inA !== 8'd8 || bus.as_inB !== 8'd8)
      begin n_fail++; $display("FAIL b2b_fwd: got A %0d B %0d want 8 8", bus.as_inA, bus.as_inB); end
    set_instr(1, 0, 6, 1, 7, 5);
    @(negedge clk);
    set_instr(0, 0, 0, 0, 0, 0);
    n_tests++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd6 || bus.rf_wdata !== 8'd16 || bus.done_tag !== 4'd4)
      begin n_fail++; $display("FAIL b2b_2: got we %b addr %0d data %0d tag %0d want 1 6 16 4", bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.done_tag); end
    @(negedge clk);
    n_tests++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd7 || bus.rf_wdata !== 8'd21 || bus.done_tag !== 4'd5)
      begin n_fail++; $display("FAIL b2b_3: got we %b addr %0d data %0d tag %0d want 1 7 21 5", bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.done_tag); end
    @(negedge clk);
  endtask

  task automatic test_distance2;
    preload(4, 100);
    set_instr(1, 0, 1, 2, 4, 6);
    @(negedge clk);
    set_instr(1, 0, 2, 2, 9, 7);
    @(negedge clk);
    set_instr(1, 1, 4, 1, 8, 8);
    @(negedge clk);
    set_instr(0, 0, 0, 0, 0, 0);
    n_tests++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd9 || bus.rf_wdata !== 8'd6)
      begin n_fail++; $display("FAIL d2_mid: got we %b addr %0d data %0d want 1 9 6", bus.rf_we, bus.rf_waddr, bus.rf_wdata); end
    n_tests++; if (bus.as_inA !== 8'd8) begin n_fail++; $display("FAIL d2_fwd: got A %0d want 8", bus.as_inA); end
    @(negedge clk);
    n_tests++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd8 || bus.rf_wdata !== 8'd3 || bus.done_tag !== 4'd8)
      begin n_fail++; $display("FAIL d2_wb: got we %b addr %0d data %0d tag %0d want 1 8 3 8", bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.done_tag); end
    @(negedge clk);
  endtask

  task automatic test_hold;
    set_instr(1, 0, 1, 2, 10, 9);
    @(negedge clk);
    set_instr(1, 1, 10, 2, 11, 10);
    @(negedge clk);
    set_instr(1, 0, 11, 1, 12, 11);
    bus.hold = 1'b1;
    #1;
    n_tests++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL hold_ready: got %b want 0", bus.in_ready); end
    n_tests++; if (bus.rf_we !== 1'b1 || bus.rf_wdata !== 8'd8 || bus.done_tag !== 4'd9)
      begin n_fail++; $display("FAIL hold_wb1: got we %b data %0d tag %0d want 1 8 9", bus.rf_we, bus.rf_wdata, bus.done_tag); end
    @(negedge clk);
    n_tests++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd11 || bus.rf_wdata !== 8'd5 || bus.done_tag !== 4'd10)
      begin n_fail++; $display("FAIL hold_wb2: got we %b addr %0d data %0d tag %0d want 1 11 5 10", bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.done_tag); end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_tests++; if (bus.rf_we !== 1'b0 || bus.busy !== 1'b0)
        begin n_fail++; $display("FAIL hold_idle%0d: got we %b busy %b want 0 0", i, bus.rf_we, bus.busy); end
    end
    bus.hold = 1'b0;
    #1;
    n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL hold_release: got %b want 1", bus.in_ready); end
    @(negedge clk);
    set_instr(0, 0, 0, 0, 0, 0);
    n_tests++; if (bus.busy !== 1'b1 || bus.as_inA !== 8'd5)
      begin n_fail++; $display("FAIL hold_resume: got busy %b A %0d want 1 5", bus.busy, bus.as_inA); end
    @(negedge clk);
    n_tests++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd12 || bus.rf_wdata !== 8'd10 || bus.done_tag !== 4'd11)
      begin n_fail++; $display("FAIL hold_wb3: got we %b addr %0d data %0d tag %0d want 1 12 10 11", bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.done_tag); end
    @(negedge clk);
  endtask

  task automatic test_dst_is_src;
    set_instr(1, 0, 2, 2, 2, 12);
    @(negedge clk);
    set_instr(1, 0, 2, 1, 3, 13);
    @(negedge clk);
    set_instr(0, 0, 0, 0, 0, 0);
    n_tests++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd2 || bus.rf_wdata !== 8'd6)
      begin n_fail++; $display("FAIL self_wb: got we %b addr %0d data %0d want 1 2 6", bus.rf_we, bus.rf_waddr, bus.rf_wdata); end
    @(negedge clk);
    n_tests++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd3 || bus.rf_wdata !== 8'd11)
      begin n_fail++; $display("FAIL self_dep: got we %b addr %0d data %0d want 1 3 11", bus.rf_we, bus.rf_waddr, bus.rf_wdata); end
    @(negedge clk);
  endtask

  task automatic test_reset_midstream;
    set_instr(1, 0, 1, 1, 13, 14);
    @(negedge clk);
    set_instr(1, 0, 1, 2, 14, 15);
    @(negedge clk);
    set_instr(0, 0, 0, 0, 0, 0);
    n_tests++; if (bus.rf_we !== 1'b1 || bus.busy !== 1'b1)
      begin n_fail++; $display("FAIL mid_pre: got we %b busy %b want 1 1", bus.rf_we, bus.busy); end
    rst = 1'b1;
    #1;
    n_tests++; if (bus.rf_we !== 1'b0 || bus.done_valid !== 1'b0 || bus.busy !== 1'b0)
      begin n_fail++; $display("FAIL mid_rst: got we %b done %b busy %b want 0 0 0", bus.rf_we, bus.done_valid, bus.busy); end
    n_tests++; if (bus.rf_wdata !== 8'd0 || bus.as_inA !== 8'd0)
      begin n_fail++; $display("FAIL mid_rst_data: got wdata %0d A %0d want 0 0", bus.rf_wdata, bus.as_inA); end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_tests++; if (bus.rf_we !== 1'b0 || bus.busy !== 1'b0)
        begin n_fail++; $display("FAIL mid_after%0d: got we %b busy %b want 0 0", i, bus.rf_we, bus.busy); end
    end
    n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready: got %b want 1", bus.in_ready); end
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    rst      = 1'b1;
    pre_we   = 1'b0;
    pre_addr = '0;
    pre_data = '0;
    bus.hold = 1'b0;
    set_instr(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    test_reset;
    test_add;
    test_sub_wrap;
    test_back_to_back;
    test_distance2;
    test_hold;
    test_dst_is_src;
    test_reset_midstream;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
